// File: rtl/sram_bank_pkg.sv
// Shared types and helpers for the SRAM bank array.
package sram_bank_pkg;

   typedef enum logic {
      INIT,
      READY
   } init_state_t;

   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/sram_bank_array_if.sv
// Bank-side bus between the AXI SRAM wrapper (master) and the bank array (slave).
interface sram_bank_array_if #(
   parameter int ROWS = 1,
   parameter int COLS = 1,
   parameter int AW   = 16,
   parameter int DW   = 32
);
   localparam int BPW = sram_bank_pkg::bytes_per_word(DW);

   logic [AW-1:0]                         bank_addr;
   logic [ROWS-1:0][COLS-1:0]             bank_cs;
   logic [ROWS-1:0][COLS-1:0]             bank_we;
   logic [ROWS-1:0][COLS-1:0][BPW-1:0]    bank_be;
   logic [COLS-1:0][DW-1:0]               bank_wdata;
   logic [ROWS-1:0][COLS-1:0][DW-1:0]     bank_rdata;

   modport master (
      output bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
      input  bank_rdata
   );

   modport slave (
      input  bank_addr, bank_cs, bank_we, bank_be, bank_wdata,
      output bank_rdata
   );

endinterface

// File: rtl/sram_bank.sv
// One single-port bank: byte-masked write and a LAT-deep read pipeline whose output
// holds the last completed read.
module sram_bank
   import sram_bank_pkg::*;
#(
   parameter int AW  = 16,
   parameter int DW  = 32,
   parameter int LAT = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          cs,
   input  logic                          we,
   input  logic [bytes_per_word(DW)-1:0] be,
   input  logic [AW-1:0]                 addr,
   input  logic [DW-1:0]                 wdata,
   output logic [DW-1:0]                 rdata
);
   localparam int BPW = bytes_per_word(DW);

   logic [DW-1:0] mem [2**AW];
   logic          rd;
   logic          wr;

   assign rd = cs & ~we;
   assign wr = cs & we;

   // Storage has no reset: contents survive reset and are cleared by the sweep.
   always_ff @(posedge clk_i) begin
      if (wr) begin
         for (int b = 0; b < BPW; b++) begin
            if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   if (LAT == 1) begin : g_lat1
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)  rdata <= '0;
         else if (rd)  rdata <= mem[addr];
      end
   end else begin : g_latn
      logic [DW-1:0]  pipe_d [LAT-1];
      logic [LAT-2:0] pipe_v;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int k = 0; k < LAT-1; k++) pipe_d[k] <= '0;
            pipe_v <= '0;
            rdata  <= '0;
         end else begin
            if (rd) pipe_d[0] <= mem[addr];
            pipe_v[0] <= rd;
            for (int k = 1; k < LAT-1; k++) begin
               pipe_d[k] <= pipe_d[k-1];
               pipe_v[k] <= pipe_v[k-1];
            end
            if (pipe_v[LAT-2]) rdata <= pipe_d[LAT-2];
         end
      end
   end

endmodule

// File: rtl/sram_bank_array.sv
// ROWS x COLS bank array behind the AXI SRAM wrapper, with a zero-fill sweep after reset.
//
//   state | meaning
//   INIT  | sweep writes zero to word cnt of every bank; external cs ignored and flagged
//   READY | external bus drives the banks
module sram_bank_array
   import sram_bank_pkg::*;
#(
   parameter int SRAM_BANKS_ROWS      = 1,
   parameter int SRAM_BANKS_COLS      = 1,
   parameter int SRAM_BANK_ADDR_WIDTH = 16,
   parameter int SRAM_BANK_DATA_WIDTH = 32,
   parameter int SRAM_READ_LATENCY    = 2,
   parameter bit INIT_ON_RESET        = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   sram_bank_array_if.slave   bus,
   output logic               init_busy_o,
   output logic               access_err_o
);
   localparam int ROWS = SRAM_BANKS_ROWS;
   localparam int COLS = SRAM_BANKS_COLS;
   localparam int AW   = SRAM_BANK_ADDR_WIDTH;
   localparam int DW   = SRAM_BANK_DATA_WIDTH;
   localparam int BPW  = bytes_per_word(DW);
   localparam init_state_t RESET_STATE = INIT_ON_RESET ? INIT : READY;

   init_state_t state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          err_q;

   logic [AW-1:0]                      addr_m;
   logic [ROWS-1:0][COLS-1:0]          cs_m;
   logic [ROWS-1:0][COLS-1:0]          we_m;
   logic [ROWS-1:0][COLS-1:0][BPW-1:0] be_m;
   logic [COLS-1:0][DW-1:0]            wdata_m;
   logic [ROWS-1:0][COLS-1:0][DW-1:0]  rdata_w;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == INIT && |bus.bank_cs) err_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_m  = bus.bank_addr;
      cs_m    = bus.bank_cs;
      we_m    = bus.bank_we;
      be_m    = bus.bank_be;
      wdata_m = bus.bank_wdata;
      case (state_q)
         INIT: begin
            addr_m  = cnt_q;
            cs_m    = '1;
            we_m    = '1;
            be_m    = '1;
            wdata_m = '0;
            cnt_d   = cnt_q + 1'b1;
            // cnt wraps back to zero here, ready for the next sweep
            if (cnt_q == '1) state_d = READY;
         end
         READY: ;
         default: state_d = READY;
      endcase
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         sram_bank #(
            .AW  (AW),
            .DW  (DW),
            .LAT (SRAM_READ_LATENCY)
         ) u_bank (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .cs     (cs_m[r][c]),
            .we     (we_m[r][c]),
            .be     (be_m[r][c]),
            .addr   (addr_m),
            .wdata  (wdata_m[c]),
            .rdata  (rdata_w[r][c])
         );
      end
   end

   assign bus.bank_rdata = rdata_w;
   assign init_busy_o    = (state_q == INIT);
   assign access_err_o   = err_q;

endmodule

// File: tb/tb_sram_bank_array.sv
// Scoreboard bench for sram_bank_array: 2x2 banks, 16-word depth, read latency 2.
module tb_sram_bank_array;
   localparam int R     = 2;
   localparam int C     = 2;
   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int LAT   = 2;
   localparam int BPW   = 4;
   localparam int DEPTH = 16;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   logic init_busy_o;
   logic access_err_o;

   sram_bank_array_if #(.ROWS(R), .COLS(C), .AW(AW), .DW(DW)) bus ();

   sram_bank_array #(
      .SRAM_BANKS_ROWS      (R),
      .SRAM_BANKS_COLS      (C),
      .SRAM_BANK_ADDR_WIDTH (AW),
      .SRAM_BANK_DATA_WIDTH (DW),
      .SRAM_READ_LATENCY    (LAT),
      .INIT_ON_RESET        (1'b1)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus),
      .init_busy_o  (init_busy_o),
      .access_err_o (access_err_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          due;
      int          r;
      int          c;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl    [R][C][DEPTH];
   logic [31:0] mdl_rd [R][C];

   logic [R-1:0][C-1:0]          cs_v, we_v;
   logic [R-1:0][C-1:0][BPW-1:0] be_v;
   logic [C-1:0][31:0]           wd_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Completed reads move into the expected-output model; every cycle all banks are compared.
   always @(negedge clk_i) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mdl_rd[sb[0].r][sb[0].c] = sb[0].data;
         void'(sb.pop_front());
      end
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            check($sformatf("rdata[%0d][%0d]", r, c), bus.bank_rdata[r][c], mdl_rd[r][c]);
   end

   task automatic drive_idle();
      bus.bank_addr  = '0;
      bus.bank_cs    = '0;
      bus.bank_we    = '0;
      bus.bank_be    = '0;
      bus.bank_wdata = '0;
   endtask

   task automatic idle(input int n);
      drive_idle();
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // One cycle of bus activity in READY; reference model updated from the access rules.
   task automatic access(input logic [AW-1:0] a);
      bus.bank_addr  = a;
      bus.bank_cs    = cs_v;
      bus.bank_we    = we_v;
      bus.bank_be    = be_v;
      bus.bank_wdata = wd_v;
      for (int r = 0; r < R; r++) begin
         for (int c = 0; c < C; c++) begin
            if (cs_v[r][c]) begin
               if (we_v[r][c]) begin
                  for (int b = 0; b < BPW; b++)
                     if (be_v[r][c][b]) mdl[r][c][a][b*8 +: 8] = wd_v[c][b*8 +: 8];
               end else begin
                  sb.push_back('{due: cyc + LAT, r: r, c: c, data: mdl[r][c][a]});
               end
            end
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_op(input logic [R-1:0][C-1:0] cs, input logic we, input logic [BPW-1:0] be);
      cs_v = cs;
      we_v = we ? '1 : '0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            be_v[r][c] = be;
   endtask

   task automatic apply_reset();
      drive_idle();
      rst_ni = 1'b0;
      sb.delete();
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            mdl_rd[r][c] = '0;
            for (int a = 0; a < DEPTH; a++) mdl[r][c][a] = '0;
         end
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (n <= 200) begin
         @(negedge clk_i);
         if (!init_busy_o) break;
         n++;
      end
      check(name, n, DEPTH);
      @(posedge clk_i);
      #1;
   endtask

   task automatic read_all_zero();
      set_op('1, 1'b0, '0);
      wd_v = '0;
      for (int a = 0; a < DEPTH; a++) access(a[AW-1:0]);
      idle(LAT + 1);
   endtask

   initial begin
      drive_idle();
      cs_v = '0; we_v = '0; be_v = '0; wd_v = '0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            mdl_rd[r][c] = '0;
            for (int a = 0; a < DEPTH; a++) mdl[r][c][a] = '0;
         end

      // Reset, sweep duration, clean flags, every word reads zero.
      apply_reset();
      check("busy_after_reset", init_busy_o, 1'b1);
      check("err_after_reset", access_err_o, 1'b0);
      wait_init("init_cycles");
      read_all_zero();

      // Byte-masked overwrite followed by read with exact latency.
      set_op(4'b0001, 1'b1, 4'hF);
      wd_v = '0; wd_v[0] = 32'hDEADBEEF;
      access(4'd5);
      set_op(4'b0001, 1'b1, 4'h1);
      wd_v[0] = 32'h000000AA;
      access(4'd5);
      set_op(4'b0001, 1'b0, 4'h0);
      access(4'd5);
      idle(1);
      check("byte_merge", bus.bank_rdata[0][0], 32'hDEADBEAA);
      set_op(4'b0001, 1'b1, 4'h0);
      wd_v[0] = 32'hFFFFFFFF;
      access(4'd5);
      idle(1);

      // Back-to-back reads; output then holds the last one.
      set_op(4'b0001, 1'b1, 4'hF);
      wd_v[0] = 32'h11; access(4'd1);
      wd_v[0] = 32'h22; access(4'd2);
      wd_v[0] = 32'h33; access(4'd3);
      set_op(4'b0001, 1'b0, 4'h0);
      access(4'd1); access(4'd2); access(4'd3);
      idle(5);
      check("hold_last", bus.bank_rdata[0][0], 32'h33);

      // Row isolation.
      set_op(4'b0011, 1'b1, 4'hF);
      wd_v[0] = 32'h55; wd_v[1] = 32'h66;
      access(4'd7);
      set_op(4'b0011, 1'b0, 4'h0);
      access(4'd7);
      set_op(4'b1100, 1'b1, 4'hF);
      wd_v[0] = 32'hA; wd_v[1] = 32'hB;
      access(4'd7);
      set_op(4'b1100, 1'b0, 4'h0);
      access(4'd7);
      idle(LAT + 1);
      check("row1_col0", bus.bank_rdata[1][0], 32'hA);
      check("row1_col1", bus.bank_rdata[1][1], 32'hB);
      check("row0_col0_kept", bus.bank_rdata[0][0], 32'h55);
      set_op(4'b0011, 1'b0, 4'h0);
      access(4'd7);
      idle(LAT + 1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         cs_v = 4'($urandom_range(0, 15));
         we_v = 4'($urandom_range(0, 15));
         for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
               be_v[r][c] = 4'($urandom_range(0, 15));
         wd_v[0] = $urandom;
         wd_v[1] = $urandom;
         access(4'($urandom_range(0, DEPTH - 1)));
      end
      idle(LAT + 2);

      // Reset while a read is in flight: output clears and the read never lands.
      set_op('1, 1'b1, 4'hF);
      wd_v[0] = 32'h12345678; wd_v[1] = 32'h9ABCDEF0;
      access(4'd9);
      set_op('1, 1'b0, 4'h0);
      access(4'd9);
      apply_reset();
      check("rdata_cleared", bus.bank_rdata[0][0], 32'h0);
      wait_init("init_cycles_after_flush");
      idle(4);
      check("no_late_read", bus.bank_rdata[1][1], 32'h0);

      // cs during INIT: no effect on the array, sticky error flag.
      apply_reset();
      idle(6);
      bus.bank_addr  = 4'd0;
      bus.bank_cs    = '1;
      bus.bank_we    = '1;
      bus.bank_be    = '1;
      bus.bank_wdata = {32'hCAFEF00D, 32'hBAADF00D};
      @(posedge clk_i);
      #1;
      drive_idle();
      check("err_set", access_err_o, 1'b1);
      for (int n = 0; n < 100 && init_busy_o; n++) idle(1);
      check("busy_done", init_busy_o, 1'b0);
      check("err_sticky", access_err_o, 1'b1);
      read_all_zero();
      check("err_still_sticky", access_err_o, 1'b1);

      // Reset mid-sweep restarts it from zero and clears the error flag.
      apply_reset();
      idle(5);
      apply_reset();
      check("err_cleared", access_err_o, 1'b0);
      wait_init("init_cycles_restart");
      read_all_zero();

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
